// File: rtl/alu_mult_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_seq_if
// Brief    : Start/busy/done handshake, operand and step-code bundle for the
//            shift-add multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_mult_seq_if #(
   parameter int WIDTH = 16
);
   logic                   start_i;
   logic [31:0]            src1_i;
   logic [31:0]            src2_i;
   logic                   busy_o;
   logic                   done_o;
   logic [2*WIDTH-1:0]     result_o;
   logic                   alu_en_o;
   logic [3:0]             ALU_operation_o;
   logic [1:0]             FURslt_o;

   // Requester side: main control issuing multiplies
   modport master (
      output start_i, src1_i, src2_i,
      input  busy_o, done_o, result_o, alu_en_o, ALU_operation_o, FURslt_o
   );

   // Sequencer side
   modport slave (
      input  start_i, src1_i, src2_i,
      output busy_o, done_o, result_o, alu_en_o, ALU_operation_o, FURslt_o
   );
endinterface
`default_nettype wire

// File: rtl/alu_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mult_seq
// Brief    : Unsigned WIDTH x WIDTH shift-add multiplier that publishes the
//            add/srl step codes so the shared execute unit can follow along.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mult_seq #(
   parameter int WIDTH = 16
) (
   input  wire logic       clk_i,
   input  wire logic       rst_i,
   alu_mult_seq_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ADD   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   localparam logic [3:0] C_OP_NONE = 4'b0000;
   localparam logic [3:0] C_OP_ADD  = 4'b0010;
   localparam logic [3:0] C_OP_SRL  = 4'b0001;
   localparam logic [1:0] C_FU_ALU  = 2'b00;
   localparam logic [1:0] C_FU_SHF  = 2'b01;

   logic [1:0]         state_q,  state_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   q_q,      q_d;
   logic [WIDTH-1:0]   m_q,      m_d;
   logic               c_q,      c_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   // Full-width sum so the carry out of the accumulator is never lost
   logic [WIDTH:0]     w_sum;
   assign w_sum = {1'b0, a_q} + {1'b0, m_q};

   // Sequencer datapath and state transitions
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      q_d      = q_q;
      m_d      = m_q;
      c_d      = c_q;
      count_d  = count_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i) begin
               m_d     = bus.src1_i[WIDTH-1:0];
               q_d     = bus.src2_i[WIDTH-1:0];
               a_d     = '0;
               c_d     = 1'b0;
               count_d = '0;
               state_d = S_ADD;
            end
         end
         S_ADD: begin
            if (q_q[0]) begin
               {c_d, a_d} = w_sum;
            end
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            // Logical right shift of the {C,A,Q} chain by one place
            c_d = 1'b0;
            a_d = {c_q, a_q[WIDTH-1:1]};
            q_d = {a_q[0], q_q[WIDTH-1:1]};
            if (count_q == C_LAST) begin
               result_d = {c_q, a_q, q_q[WIDTH-1:1]};
               state_d  = S_DONE;
            end else begin
               count_d = count_q + CNT_W'(1);
               state_d = S_ADD;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Step codes and handshake decoded from the current state
   always_comb begin
      bus.busy_o          = (state_q != S_IDLE);
      bus.done_o          = 1'b0;
      bus.alu_en_o        = 1'b0;
      bus.ALU_operation_o = C_OP_NONE;
      bus.FURslt_o        = C_FU_ALU;
      case (state_q)
         S_ADD: begin
            bus.alu_en_o        = q_q[0];
            bus.ALU_operation_o = C_OP_ADD;
            bus.FURslt_o        = C_FU_ALU;
         end
         S_SHIFT: begin
            bus.ALU_operation_o = C_OP_SRL;
            bus.FURslt_o        = C_FU_SHF;
         end
         S_DONE: begin
            bus.done_o = 1'b1;
         end
         default: begin
            bus.done_o = 1'b0;
         end
      endcase
      bus.result_o = result_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         q_q      <= '0;
         m_q      <= '0;
         c_q      <= 1'b0;
         count_q  <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         q_q      <= q_d;
         m_q      <= m_d;
         c_q      <= c_d;
         count_q  <= count_d;
         result_q <= result_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_mult_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_alu_mult_seq
// Brief    : Self-checking bench for alu_mult_seq against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mult_seq;

   localparam int WIDTH = 16;

   logic        clk = 1'b0;
   logic        rst;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_result;

   alu_mult_seq_if #(.WIDTH(WIDTH)) bus ();

   alu_mult_seq #(.WIDTH(WIDTH)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] obs_vec();
      return {23'b0, bus.result_o, bus.busy_o, bus.done_o, bus.alu_en_o,
              bus.ALU_operation_o, bus.FURslt_o};
   endfunction

   function automatic logic [63:0] mk(input logic [31:0] res, input logic busy,
                                      input logic done, input logic en,
                                      input logic [3:0] op, input logic [1:0] fs);
      return {23'b0, res, busy, done, en, op, fs};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full multiply from IDLE; optional stray start pulse at cycle pulse_at
   task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input int pulse_at);
      logic [31:0] prod;
      logic [15:0] mb;
      prod = 32'(a[15:0]) * 32'(b[15:0]);
      mb   = b[15:0];
      bus.start_i = 1'b1;
      bus.src1_i  = a;
      bus.src2_i  = b;
      tick();
      bus.start_i = 1'b0;
      for (int k = 1; k <= 2*WIDTH; k++) begin
         if (k % 2 == 1)
            chk($sformatf("%0h*%0h add k=%0d", a, b, k), obs_vec(),
                mk(exp_result, 1'b1, 1'b0, mb[(k-1)/2], 4'b0010, 2'b00));
         else
            chk($sformatf("%0h*%0h srl k=%0d", a, b, k), obs_vec(),
                mk(exp_result, 1'b1, 1'b0, 1'b0, 4'b0001, 2'b01));
         if (k == pulse_at) begin
            bus.start_i = 1'b1;
            bus.src1_i  = $urandom;
            bus.src2_i  = $urandom;
         end else if (k == pulse_at + 1) begin
            bus.start_i = 1'b0;
         end
         tick();
      end
      exp_result = prod;
      chk($sformatf("%0h*%0h done", a, b), obs_vec(),
          mk(exp_result, 1'b1, 1'b1, 1'b0, 4'b0000, 2'b00));
      tick();
      chk($sformatf("%0h*%0h idle", a, b), obs_vec(),
          mk(exp_result, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00));
   endtask

   initial begin
      int dones;
      int last;
      int pulses;
      int gap;

      rst         = 1'b1;
      bus.start_i = 1'b0;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      exp_result  = '0;
      tick();
      tick();
      rst = 1'b0;
      chk("reset", obs_vec(), mk(32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00));

      // Directed cases
      run_mult(32'd3, 32'd5, 0);
      run_mult(32'h0000FFFF, 32'h0000FFFF, 0);
      run_mult(32'h00001234, 32'h00000000, 0);
      run_mult(32'hABCD0007, 32'hFFFF0009, 0);
      run_mult($urandom, $urandom, 10);

      // Reset in the middle of a multiply
      bus.start_i = 1'b1;
      bus.src1_i  = 32'h1111;
      bus.src2_i  = 32'h2222;
      tick();
      bus.start_i = 1'b0;
      repeat (11) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_result = '0;
      chk("rst_mid", obs_vec(), mk(32'h0, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00));
      dones = 0;
      repeat (40) begin
         tick();
         if (bus.done_o) dones++;
      end
      chk("rst_no_done", 64'(dones), 64'd0);
      run_mult(32'd7, 32'd9, 0);

      // Held start: periodic restarts with a one-cycle IDLE gap
      bus.start_i = 1'b1;
      bus.src1_i  = 32'd2;
      bus.src2_i  = 32'd3;
      last   = -1;
      pulses = 0;
      for (int cyc = 0; cyc < 200 && pulses < 4; cyc++) begin
         tick();
         if (bus.done_o) begin
            pulses++;
            if (last >= 0) chk("hold_period", 64'(cyc - last), 64'd34);
            chk("hold_result", 64'(bus.result_o), 64'd6);
            last = cyc;
         end
      end
      chk("hold_pulses", 64'(pulses), 64'd4);
      bus.start_i = 1'b0;
      exp_result  = 32'd6;
      tick();
      tick();
      chk("hold_idle", obs_vec(), mk(exp_result, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00));

      // Random operands with random idle gaps
      for (int i = 0; i < 8; i++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            chk("gap_idle", obs_vec(), mk(exp_result, 1'b0, 1'b0, 1'b0, 4'b0000, 2'b00));
         end
         run_mult($urandom, $urandom, (i % 2 == 0) ? $urandom_range(1, 30) : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
